vaga_sensor_filter: RTL and testbench

// Front end of the parking-space sensor path. Synchronises and debounces the raw presence

---
 rtl/vaga_sensor_filter.sv | 136 +++++++++++++
 tb/tb_vaga_sensor_filter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vaga_sensor_filter.sv
// Debounces one parking-space presence pin into a clean occupied level plus arrive/depart pulses.
// Latency: a raw step sampled at edge 1 is accepted at edge STABLE_CYCLES+2. No backpressure (free-running).
// Optional DWELL_COUNTER_EN macro adds a saturating occupancy-duration counter reported on last_dwell.
module vaga_sensor_filter #(
    parameter int STABLE_CYCLES = 6,
    parameter int DWELL_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sensor_raw,
    output logic               sensor,
    output logic               arrive_pulse,
    output logic               depart_pulse,
    output logic [DWELL_W-1:0] last_dwell
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_cfg_check
            $error("vaga_sensor_filter: STABLE_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        ARRIVING = 2'd1,
        OCCUPIED = 2'd2,
        LEAVING  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync_q1;
    logic             sync_q2;
    logic             s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sensor_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FREE;
            cnt          <= '0;
            sensor       <= 1'b0;
            arrive_pulse <= 1'b0;
            depart_pulse <= 1'b0;
        end else begin
            arrive_pulse <= 1'b0;
            depart_pulse <= 1'b0;
            case (state)
                FREE: begin
                    if (s) begin
                        state <= ARRIVING;
                        cnt   <= CNT_W'(1);
                    end
                end
                ARRIVING: begin
                    if (!s) begin
                        state <= FREE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= OCCUPIED;
                        sensor       <= 1'b1;
                        arrive_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OCCUPIED: begin
                    if (!s) begin
                        state <= LEAVING;
                        cnt   <= CNT_W'(1);
                    end
                end
                LEAVING: begin
                    if (s) begin
                        state <= OCCUPIED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= FREE;
                        sensor       <= 1'b0;
                        depart_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= FREE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DWELL_COUNTER_EN
    logic [DWELL_W-1:0] dwell_cnt;
    logic               arr_accept;
    logic               dep_accept;

    assign arr_accept = (state == ARRIVING) && s && (cnt == CNT_LAST);
    assign dep_accept = (state == LEAVING) && !s && (cnt == CNT_LAST);

    // last_dwell samples the count before this edge's increment, so it excludes the depart cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt  <= '0;
            last_dwell <= '0;
        end else begin
            if (arr_accept) begin
                dwell_cnt <= '0;
            end else if (((state == OCCUPIED) || (state == LEAVING)) && (dwell_cnt != '1)) begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
            if (dep_accept) begin
                last_dwell <= dwell_cnt;
            end
        end
    end
`else
    assign last_dwell = '0;
`endif

endmodule

// File: tb/tb_vaga_sensor_filter.sv
// Directed bench for vaga_sensor_filter: a run-length model of the debounce rule is compared every cycle,
// plus hand-computed literal expectations for latency, glitch rejection, reset and dwell.
module tb_vaga_sensor_filter;

    localparam int STABLE  = 6;
    localparam int DW      = 4;
    localparam int DW_MAX  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sensor_raw;
    logic          sensor;
    logic          arrive_pulse;
    logic          depart_pulse;
    logic [DW-1:0] last_dwell;

    int checks = 0;
    int errors = 0;
    int arr_cnt = 0;
    int dep_cnt = 0;
    bit cmp_en = 1'b0;

    vaga_sensor_filter #(.STABLE_CYCLES(STABLE), .DWELL_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_raw   (sensor_raw),
        .sensor       (sensor),
        .arrive_pulse (arrive_pulse),
        .depart_pulse (depart_pulse),
        .last_dwell   (last_dwell)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted level flips once the synced input has disagreed with it
    // for STABLE consecutive samples; any agreeing sample restarts the run.
    logic m_level = 1'b0;
    logic m_arr   = 1'b0;
    logic m_dep   = 1'b0;
    int   m_last  = 0;
    logic hist1   = 1'b0;
    logic hist2   = 1'b0;
    logic m_s     = 1'b0;
    int   run     = 0;
    int   cyc     = 0;
    int   arr_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1   = 1'b0;
            hist2   = 1'b0;
            m_level = 1'b0;
            m_arr   = 1'b0;
            m_dep   = 1'b0;
            m_last  = 0;
            run     = 0;
        end else begin
            cyc++;
            m_s   = hist2;
            hist2 = hist1;
            hist1 = sensor_raw;
            m_arr = 1'b0;
            m_dep = 1'b0;
            if (m_s == m_level) begin
                run = 0;
            end else begin
                run++;
                if (run == STABLE) begin
                    m_level = m_s;
                    run     = 0;
                    if (m_s) begin
                        m_arr   = 1'b1;
                        arr_cyc = cyc;
                    end else begin
                        m_dep = 1'b1;
`ifdef DWELL_COUNTER_EN
                        m_last = (cyc - arr_cyc - 1 > DW_MAX) ? DW_MAX : cyc - arr_cyc - 1;
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (arrive_pulse === 1'b1) arr_cnt++;
        if (depart_pulse === 1'b1) dep_cnt++;
        if (cmp_en) begin
            check("cyc_sensor", int'(sensor), int'(m_level));
            check("cyc_arrive", int'(arrive_pulse), int'(m_arr));
            check("cyc_depart", int'(depart_pulse), int'(m_dep));
            check("cyc_last_dwell", int'(last_dwell), m_last);
            check("cyc_pulse_excl", int'(arrive_pulse & depart_pulse), 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a0;
        int d0;
        int hi;
        int lo;
        rst_n      = 1'b0;
        sensor_raw = 1'b0;
        cycles(3);
        check("rst_sensor", int'(sensor), 0);
        check("rst_arrive", int'(arrive_pulse), 0);
        check("rst_depart", int'(depart_pulse), 0);
        check("rst_last_dwell", int'(last_dwell), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cycles(4);

        // Clean arrival: accepted at edge 8 after the step
        sensor_raw = 1'b1;
        cycles(7);
        check("arr_edge7_sensor", int'(sensor), 0);
        cycles(1);
        check("arr_edge8_sensor", int'(sensor), 1);
        check("arr_edge8_pulse", int'(arrive_pulse), 1);
        cycles(1);
        check("arr_edge9_pulse", int'(arrive_pulse), 0);
        check("arr_edge9_sensor", int'(sensor), 1);
        cycles(4);

        // Five-cycle low while occupied is rejected
        d0 = dep_cnt;
        sensor_raw = 1'b0;
        cycles(5);
        sensor_raw = 1'b1;
        cycles(12);
        check("glitch_occ_sensor", int'(sensor), 1);
        check("glitch_occ_depart", dep_cnt - d0, 0);

        // Departure: accepted at edge 8 after the step
        sensor_raw = 1'b0;
        cycles(7);
        check("dep_edge7_sensor", int'(sensor), 1);
        cycles(1);
        check("dep_edge8_sensor", int'(sensor), 0);
        check("dep_edge8_pulse", int'(depart_pulse), 1);
        cycles(1);
        check("dep_edge9_pulse", int'(depart_pulse), 0);
        cycles(4);

        // Five-cycle high while free is rejected
        a0 = arr_cnt;
        sensor_raw = 1'b1;
        cycles(5);
        sensor_raw = 1'b0;
        cycles(12);
        check("glitch_free_sensor", int'(sensor), 0);
        check("glitch_free_arrive", arr_cnt - a0, 0);

        // Reset mid-ARRIVING aborts the pending change
        a0 = arr_cnt;
        sensor_raw = 1'b1;
        cycles(4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_arriving_sensor", int'(sensor), 0);
        check("rst_arriving_arrive", int'(arrive_pulse), 0);
        sensor_raw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(12);
        check("rst_arriving_nopulse", arr_cnt - a0, 0);

        // Reset while occupied clears sensor asynchronously, no depart afterwards
        sensor_raw = 1'b1;
        cycles(10);
        check("rst_occ_pre_sensor", int'(sensor), 1);
        d0 = dep_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rst_occ_sensor", int'(sensor), 0);
        check("rst_occ_depart", int'(depart_pulse), 0);
        sensor_raw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(12);
        check("rst_occ_nopulse", dep_cnt - d0, 0);

        // Dwell: 10-cycle raw stay, then 30-cycle raw stay
        sensor_raw = 1'b1;
        cycles(10);
        sensor_raw = 1'b0;
        cycles(12);
`ifdef DWELL_COUNTER_EN
        check("dwell_10", int'(last_dwell), 9);
`else
        check("dwell_10", int'(last_dwell), 0);
`endif
        sensor_raw = 1'b1;
        cycles(30);
        sensor_raw = 1'b0;
        cycles(12);
`ifdef DWELL_COUNTER_EN
        check("dwell_30_sat", int'(last_dwell), DW_MAX);
`else
        check("dwell_30", int'(last_dwell), 0);
`endif

        // 50 stays of random length, each long enough to be accepted
        a0 = arr_cnt;
        d0 = dep_cnt;
        for (int i = 0; i < 50; i++) begin
            hi = $urandom_range(20, STABLE);
            lo = $urandom_range(20, STABLE);
            sensor_raw = 1'b1;
            cycles(hi);
            sensor_raw = 1'b0;
            cycles(lo);
        end
        cycles(12);
        check("rand_arrivals", arr_cnt - a0, 50);
        check("rand_balance", arr_cnt - a0, dep_cnt - d0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
